// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory with sized loads/stores,
// registered read data with a valid strobe, a post-reset zeroing sweep,
// fault tracking (illegal size, out of range, misaligned) and a
// combinational debug word port.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 32,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            data_i,
    output logic                   ready_o,
    output logic [31:0]            rdata_o,
    output logic                   rvalid_o,
    output logic                   fault_o,
    output logic [1:0]             fault_code_o,
    output logic [31:0]            fault_addr_o,
    output logic [FAULT_CNT_W-1:0] fault_cnt_o,
    input  logic [31:0]            dbg_addr_i,
    output logic [31:0]            dbg_data_o
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int PW    = AW - 2;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   init_ptr_q, init_ptr_d;
    logic [7:0]      mem [DEPTH_BYTES];

    logic [32:0]     span;
    logic [32:0]     last_addr;
    logic            illegal_size;
    logic            out_of_range;
    logic            misaligned;
    logic [1:0]      code_now;
    logic            has_fault;
    logic            accept;
    logic            store_en;
    logic [AW-1:0]   idx0, idx1, idx2, idx3;
    logic [31:0]     load_val;
    logic [AW-1:0]   dbg_base;

    // State register: reset restarts the zeroing sweep from word 0
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Next-state: sweep one word per cycle, then park in IDLE forever
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ready_o    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + PW'(1);
                if (init_ptr_q == PW'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready_o = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Access decode; the 33-bit end address keeps high addresses from wrapping into range
    always_comb begin
        case (size_i)
            2'b00:   span = 33'd0;
            2'b01:   span = 33'd1;
            default: span = 33'd3;
        endcase
        last_addr    = {1'b0, addr_i} + span;
        illegal_size = (size_i == 2'b11);
        out_of_range = (last_addr >= 33'(DEPTH_BYTES));
        misaligned   = ((size_i == 2'b01) && addr_i[0]) ||
                       ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
        if (illegal_size) begin
            code_now = 2'b11;
        end else if (out_of_range) begin
            code_now = 2'b10;
        end else if (misaligned) begin
            code_now = 2'b01;
        end else begin
            code_now = 2'b00;
        end
        has_fault = (code_now != 2'b00);
        accept    = req_i && ready_o;
        store_en  = accept && we_i && !has_fault;
    end

    // Byte lane indices; upper lanes are only used for aligned, in-range accesses
    always_comb begin
        idx0 = addr_i[AW-1:0];
        idx1 = {addr_i[AW-1:1], 1'b1};
        idx2 = {addr_i[AW-1:2], 2'b10};
        idx3 = {addr_i[AW-1:2], 2'b11};
        case (size_i)
            2'b00:   load_val = unsigned_i ? {24'h0, mem[idx0]}
                                           : {{24{mem[idx0][7]}}, mem[idx0]};
            2'b01:   load_val = unsigned_i ? {16'h0, mem[idx1], mem[idx0]}
                                           : {{16{mem[idx1][7]}}, mem[idx1], mem[idx0]};
            default: load_val = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
        endcase
    end

    // Memory array: sweep writes zeros in INIT, stores write little-endian lanes in IDLE
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem[{init_ptr_q, 2'b00}] <= 8'h00;
            mem[{init_ptr_q, 2'b01}] <= 8'h00;
            mem[{init_ptr_q, 2'b10}] <= 8'h00;
            mem[{init_ptr_q, 2'b11}] <= 8'h00;
        end else if (store_en) begin
            mem[idx0] <= data_i[7:0];
            if (size_i != 2'b00) begin
                mem[idx1] <= data_i[15:8];
            end
            if (size_i == 2'b10) begin
                mem[idx2] <= data_i[23:16];
                mem[idx3] <= data_i[31:24];
            end
        end
    end

    // Registered load result, strobes and fault bookkeeping
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rdata_o      <= '0;
            rvalid_o     <= 1'b0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'b00;
            fault_addr_o <= '0;
            fault_cnt_o  <= '0;
        end else begin
            rvalid_o <= accept && !we_i;
            fault_o  <= accept && has_fault;
            if (accept && !we_i) begin
                rdata_o <= has_fault ? 32'h0 : load_val;
            end
            if (accept && has_fault) begin
                fault_code_o <= code_now;
                fault_addr_o <= addr_i;
                if (fault_cnt_o != '1) begin
                    fault_cnt_o <= fault_cnt_o + FAULT_CNT_W'(1);
                end
            end
        end
    end

    // Debug word read of committed memory; zero outside the array
    always_comb begin
        dbg_base = {dbg_addr_i[AW-1:2], 2'b00};
        if (dbg_addr_i < 32'(DEPTH_BYTES)) begin
            dbg_data_o = {mem[dbg_base | AW'(3)], mem[dbg_base | AW'(2)],
                          mem[dbg_base | AW'(1)], mem[dbg_base]};
        end else begin
            dbg_data_o = 32'h0;
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised byte-addressable data memory for the single-cycle/pipelined core.
- Adds sized loads and stores (byte/half/word) with sign or zero extension, a registered read with a valid strobe, and a post-reset zeroing sweep.
- Adds fault tracking for misaligned, out-of-range and illegal-size accesses.
- Keeps a combinational debug word port for the fault-track display logic.

Parameters:
- DEPTH_BYTES, 32, memory size in bytes; power of two, >= 8.
- FAULT_CNT_W, 8, width of the saturating fault counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  1  access request; accepted when req_i && ready_o at a clock edge.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- data_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready_o  out  1  high in IDLE, low during the INIT sweep.
- rdata_o  out  32  load result; holds its value until the next accepted load.
- rvalid_o  out  1  one-cycle pulse, one cycle after each accepted load.
- fault_o  out  1  one-cycle pulse, one cycle after a faulting accepted access.
- fault_code_o  out  2  last fault: 01 misaligned, 10 out of range, 11 illegal size; holds.
- fault_addr_o  out  32  addr_i of the last faulting access; holds.
- fault_cnt_o  out  FAULT_CNT_W  total faults, saturating at all-ones.
- dbg_addr_i  in  32  debug read address.
- dbg_data_o  out  32  combinational little-endian word at {dbg_addr_i[31:2],2'b00}; 0 if out of range.

Behaviour:
- Reset is asserted asynchronously:
  - rdata_o, rvalid_o, fault_o, fault_code_o, fault_addr_o and fault_cnt_o clear to 0; ready_o = 0.
  - The FSM enters INIT with init_ptr = 0.
  - Memory arrays are not reset directly.
- INIT: each cycle, zero word init_ptr (4 bytes) and increment init_ptr. After word DEPTH_BYTES/4-1 is cleared, go to IDLE; ready_o rises on that edge.
  - req_i is ignored in INIT: no write, no rvalid_o, no fault.
- IDLE: stays in IDLE; each accepted access is decoded with fault priority illegal size > out of range > misaligned.
  - Illegal size: size_i == 11.
  - Out of range: addr_i + bytes - 1 >= DEPTH_BYTES, computed at 33 bits so there is no wrap-around.
  - Misaligned: half with addr_i[0] = 1, or word with addr_i[1:0] != 0.
- Faulting access:
  - Memory is unchanged.
  - fault_o pulses on the next cycle; fault_code_o and fault_addr_o update on that same edge.
  - fault_cnt_o increments unless it is saturated.
  - A faulting load still pulses rvalid_o, with rdata_o = 0, so the pipeline never stalls.
- Store: byte lanes are written little-endian at the edge of acceptance. Byte writes addr; half writes addr..addr+1; word writes addr..addr+3.
- Load: sampled at the edge of acceptance; rdata_o and rvalid_o are valid the following cycle (latency 1).
  - Byte loads extend from bit 7 and half loads from bit 15, unless unsigned_i = 1.
- Back-to-back accesses are accepted every cycle.
- A store at cycle N followed by a load of the same address at N+1 returns the new data.
- dbg_data_o is purely combinational and reflects committed memory. During the edge of a store it shows pre-store contents until after that edge.
- Reset mid-sweep or mid-access: the in-flight rvalid_o and fault_o pulses are cancelled, and the sweep restarts from word 0.

Test Plan:
- Reset, then count cycles -> ready_o = 0 for exactly DEPTH_BYTES/4 = 8 cycles, then 1; dbg_data_o = 0 at every word.
- Word store 0xDEADBEEF @4, then loads @4: byte signed -> 0xFFFFFFEF; half unsigned @6 -> 0x0000DEAD; word -> 0xDEADBEEF.
  - Each rvalid_o pulse arrives exactly one cycle after its request.
- Byte store 0x80 @9, signed byte load @9 -> 0xFFFFFF80; unsigned -> 0x00000080. dbg_addr_i = 8 -> 0x00008000.
- Misaligned word load @2 -> fault_o pulse, fault_code_o = 01, fault_addr_o = 2, rvalid_o with rdata_o = 0, fault_cnt_o = 1.
- Word store @30 (out of range) -> fault_code_o = 10, memory bytes 28-31 unchanged.
  - Then a size 11 access -> fault_code_o = 11; with FAULT_CNT_W = 2 and 5 faults total, fault_cnt_o saturates at 3.
- Assert reset during the cycle a load is accepted -> no rvalid_o pulse, all outputs 0, INIT restarts and re-zeroes previously written data.
